// File: rtl/nand_phy_dqs_wr_seq_if.sv
// Write-burst request/status bundle between a NAND controller and the DQS write sequencer.
// The controller drives the request side; the sequencer returns status and pad controls.
interface nand_phy_dqs_wr_seq_if #(
  parameter int LEN_W = 16
);
  logic             wr_start;
  logic [LEN_W-1:0] wr_cycles;
  logic             busy;
  logic             done;
  logic             wr_err;
  logic             data_req;
  logic             dq_oe_n;
  logic             dqs_oe_n;
  logic             dqs_rst_n;

  modport master (
    output wr_start, wr_cycles,
    input  busy, done, wr_err, data_req, dq_oe_n, dqs_oe_n, dqs_rst_n
  );

  modport slave (
    input  wr_start, wr_cycles,
    output busy, done, wr_err, data_req, dq_oe_n, dqs_oe_n, dqs_rst_n
  );
endinterface

// File: rtl/nand_phy_dqs_wr_seq.sv
// NAND PHY DQS write sequencer: preamble, data burst and postamble on DQ/DQS, all outputs registered.
// Optional macro NAND_DQS_WR_ABORT_EN adds wr_abort, which cuts PRE/DATA short into a full PST.
module nand_phy_dqs_wr_seq #(
  parameter int PRE_CYCLES = 1,
  parameter int PST_CYCLES = 1,
  parameter int LEN_W      = 16
) (
  input logic clk0,
  input logic rst0_n,
`ifdef NAND_DQS_WR_ABORT_EN
  input logic wr_abort,
`endif
  nand_phy_dqs_wr_seq_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_PST} state_e;

  localparam logic [3:0]       PRE_LD = 4'(PRE_CYCLES - 1);
  localparam logic [3:0]       PST_LD = 4'(PST_CYCLES - 1);
  localparam logic [LEN_W-1:0] ONE    = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           r_state, w_state_nxt;
  logic [3:0]       r_tmr, w_tmr_nxt;
  logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_done_nxt, w_err_nxt, w_abort;

  logic r_busy, r_done, r_err, r_data_req, r_dq_oe_n, r_dqs_oe_n, r_dqs_rst_n;

`ifdef NAND_DQS_WR_ABORT_EN
  assign w_abort = wr_abort;
`else
  assign w_abort = 1'b0;
`endif

  // r_tmr times the fixed-length PRE/PST phases; r_cnt holds the remaining DATA periods.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.wr_start) begin
          if (bus.wr_cycles != '0) begin
            w_state_nxt = S_PRE;
            w_tmr_nxt   = PRE_LD;
            w_cnt_nxt   = bus.wr_cycles;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_PRE: begin
        if (w_abort) begin
          w_state_nxt = S_PST;
          w_tmr_nxt   = PST_LD;
          w_cnt_nxt   = '0;
        end else if (r_tmr == 4'd0) begin
          w_state_nxt = S_DATA;
        end else begin
          w_tmr_nxt = r_tmr - 4'd1;
        end
      end
      S_DATA: begin
        if (w_abort || r_cnt == ONE) begin
          w_state_nxt = S_PST;
          w_tmr_nxt   = PST_LD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - ONE;
        end
      end
      S_PST: begin
        if (r_tmr == 4'd0) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= 4'd0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_data_req  <= 1'b0;
      r_dq_oe_n   <= 1'b1;
      r_dqs_oe_n  <= 1'b1;
      r_dqs_rst_n <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      r_state     <= w_state_nxt;
      r_tmr       <= w_tmr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_data_req  <= (w_state_nxt == S_DATA);
      r_dq_oe_n   <= (w_state_nxt != S_DATA);
      r_dqs_oe_n  <= (w_state_nxt == S_IDLE);
      r_dqs_rst_n <= (w_state_nxt == S_DATA);
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wr_err    = r_err;
  assign bus.data_req  = r_data_req;
  assign bus.dq_oe_n   = r_dq_oe_n;
  assign bus.dqs_oe_n  = r_dqs_oe_n;
  assign bus.dqs_rst_n = r_dqs_rst_n;

endmodule

// File: tb/tb_nand_phy_dqs_wr_seq.sv
// Bench for nand_phy_dqs_wr_seq: two instances (PRE/PST = 1/1 and 3/2) share stimulus and are
// checked every cycle against a burst-timeline model, plus literal pins on cycle counts.
module tb_nand_phy_dqs_wr_seq;

  localparam logic [6:0] IDLE_VEC = 7'b0000110; // {busy,done,err,dreq,dq_oe_n,dqs_oe_n,dqs_rst_n}

  logic        clk0 = 1'b0;
  logic        rst0_n;
  logic        start;
  logic [15:0] cyc;
  logic        abort;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk0 = ~clk0;

  nand_phy_dqs_wr_seq_if #(.LEN_W(16)) if_a ();
  nand_phy_dqs_wr_seq_if #(.LEN_W(16)) if_b ();

  assign if_a.wr_start  = start;
  assign if_a.wr_cycles = cyc;
  assign if_b.wr_start  = start;
  assign if_b.wr_cycles = cyc;

  nand_phy_dqs_wr_seq #(.PRE_CYCLES(1), .PST_CYCLES(1), .LEN_W(16)) u_dut_a (
    .clk0(clk0),
    .rst0_n(rst0_n),
`ifdef NAND_DQS_WR_ABORT_EN
    .wr_abort(abort),
`endif
    .bus(if_a)
  );

  nand_phy_dqs_wr_seq #(.PRE_CYCLES(3), .PST_CYCLES(2), .LEN_W(16)) u_dut_b (
    .clk0(clk0),
    .rst0_n(rst0_n),
`ifdef NAND_DQS_WR_ABORT_EN
    .wr_abort(abort),
`endif
    .bus(if_b)
  );

  wire [6:0] w_act_a = {if_a.busy, if_a.done, if_a.wr_err, if_a.data_req,
                        if_a.dq_oe_n, if_a.dqs_oe_n, if_a.dqs_rst_n};
  wire [6:0] w_act_b = {if_b.busy, if_b.done, if_b.wr_err, if_b.data_req,
                        if_b.dq_oe_n, if_b.dqs_oe_n, if_b.dqs_rst_n};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pre_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int pst_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  // Model: m_t is the 1-based cycle index inside the burst (0 = idle); phase boundaries are absolute.
  int   m_t[2], m_pre_end[2], m_data_end[2], m_pst_end[2];
  logic e_done[2], e_err[2];

  always @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      for (int i = 0; i < 2; i++) begin
        m_t[i]    <= 0;
        e_done[i] <= 1'b0;
        e_err[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_done[i] <= 1'b0;
        e_err[i]  <= 1'b0;
        if (m_t[i] == 0) begin
          if (start) begin
            if (cyc != 16'd0) begin
              m_t[i]        <= 1;
              m_pre_end[i]  <= pre_of(i);
              m_data_end[i] <= pre_of(i) + int'(cyc);
              m_pst_end[i]  <= pre_of(i) + int'(cyc) + pst_of(i);
            end else begin
              e_err[i] <= 1'b1;
            end
          end
        end else if (m_t[i] == m_pst_end[i]) begin
          m_t[i]    <= 0;
          e_done[i] <= 1'b1;
        end else begin
          m_t[i] <= m_t[i] + 1;
          if (abort && m_t[i] <= m_data_end[i]) begin
            if (m_t[i] < m_pre_end[i]) m_pre_end[i] <= m_t[i];
            m_data_end[i] <= m_t[i];
            m_pst_end[i]  <= m_t[i] + pst_of(i);
          end
        end
      end
    end
  end

  function automatic logic [6:0] exp_vec(input int i);
    logic dr;
    dr = (m_t[i] > m_pre_end[i]) && (m_t[i] <= m_data_end[i]);
    return {m_t[i] != 0, e_done[i], e_err[i], dr, ~dr, m_t[i] == 0, dr};
  endfunction

  logic cmp_en = 1'b0;

  always @(negedge clk0) begin
    if (cmp_en) begin
      check("out_a", {25'd0, w_act_a}, {25'd0, exp_vec(0)});
      check("out_b", {25'd0, w_act_b}, {25'd0, exp_vec(1)});
    end
  end

  // Cycle-count measurements used by the literal expectations.
  int cyc_no;
  int c_oe[2], c_rst[2], c_dreq[2], c_busy[2], c_done[2], c_err[2], done_at[2], last_done[2];

  task automatic clr_meas();
    cyc_no = 0;
    for (int i = 0; i < 2; i++) begin
      c_oe[i] = 0; c_rst[i] = 0; c_dreq[i] = 0; c_busy[i] = 0;
      c_done[i] = 0; c_err[i] = 0; done_at[i] = 0; last_done[i] = 0;
    end
  endtask

  always @(negedge clk0) begin
    logic [6:0] v;
    cyc_no++;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? w_act_a : w_act_b;
      if (!v[1]) c_oe[i]++;
      if (v[0])  c_rst[i]++;
      if (v[3])  c_dreq[i]++;
      if (v[6])  c_busy[i]++;
      if (v[4])  c_err[i]++;
      if (v[5]) begin
        c_done[i]++;
        if (done_at[i] == 0) done_at[i] = cyc_no;
        last_done[i] = cyc_no;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk0);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [15:0] c);
    start = 1'b1;
    cyc   = c;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k;
    for (k = 0; k < budget && (if_a.busy || if_b.busy); k++) step(1);
    check(nm, 32'(k < budget), 32'd1);
  endtask

  task automatic wait_dreq_a(input int n, input string nm);
    int k;
    for (k = 0; k < 100 && c_dreq[0] < n; k++) step(1);
    check(nm, 32'(k < 100), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst0_n = 1'b0;
    start  = 1'b0;
    cyc    = 16'd0;
    abort  = 1'b0;
    clr_meas();
    step(3);
    check("reset_a", {25'd0, w_act_a}, {25'd0, IDLE_VEC});
    check("reset_b", {25'd0, w_act_b}, {25'd0, IDLE_VEC});
    cmp_en = 1'b1;
    rst0_n = 1'b1;
    step(2);

    // Basic burst of 4
    clr_meas();
    pulse_start(16'd4);
    wait_idle(50, "burst4_idle");
    step(2);
    check("burst4_a_oe_low",  32'(c_oe[0]),    32'd6);
    check("burst4_a_rst_hi",  32'(c_rst[0]),   32'd4);
    check("burst4_a_dreq",    32'(c_dreq[0]),  32'd4);
    check("burst4_a_done_at", 32'(done_at[0]), 32'd7);
    check("burst4_b_oe_low",  32'(c_oe[1]),    32'd9);
    check("burst4_b_done_at", 32'(done_at[1]), 32'd10);

    // Zero-length request is rejected
    clr_meas();
    pulse_start(16'd0);
    step(3);
    check("zero_a_err",  32'(c_err[0]),  32'd1);
    check("zero_a_busy", 32'(c_busy[0]), 32'd0);
    check("zero_a_oe",   32'(c_oe[0]),   32'd0);
    check("zero_b_err",  32'(c_err[1]),  32'd1);

    // Back-to-back bursts: second start issued in the done cycle of instance b
    clr_meas();
    pulse_start(16'd1);
    for (k = 0; k < 50 && !if_b.done; k++) step(1);
    check("b2b_done_seen", 32'(k < 50), 32'd1);
    pulse_start(16'd1);
    wait_idle(50, "b2b_idle");
    step(2);
    check("b2b_b_busy",      32'(c_busy[1]),    32'd12);
    check("b2b_b_done_cnt",  32'(c_done[1]),    32'd2);
    check("b2b_b_done_last", 32'(last_done[1]), 32'd14);
    check("b2b_b_dreq",      32'(c_dreq[1]),    32'd2);
    check("b2b_a_busy",      32'(c_busy[0]),    32'd6);

    // Asynchronous reset during DATA cycle 2 of 8
    clr_meas();
    pulse_start(16'd8);
    wait_dreq_a(2, "rst_reach_data2");
    #2;
    rst0_n = 1'b0;
    #1;
    check("async_rst_a", {25'd0, w_act_a}, {25'd0, IDLE_VEC});
    check("async_rst_b", {25'd0, w_act_b}, {25'd0, IDLE_VEC});
    step(3);
    rst0_n = 1'b1;
    step(4);
    check("async_rst_no_done_a", 32'(c_done[0]), 32'd0);
    check("async_rst_no_done_b", 32'(c_done[1]), 32'd0);

    // First start immediately after reset release
    rst0_n = 1'b0;
    step(2);
    rst0_n = 1'b1;
    clr_meas();
    pulse_start(16'd2);
    wait_idle(50, "post_rst_idle");
    step(2);
    check("post_rst_a_done_at", 32'(done_at[0]), 32'd5);

`ifdef NAND_DQS_WR_ABORT_EN
    // Abort in DATA cycle 3 of 10
    clr_meas();
    pulse_start(16'd10);
    wait_dreq_a(3, "abort_reach_data3");
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    wait_idle(50, "abort_idle");
    step(2);
    check("abort_a_dreq",    32'(c_dreq[0]),  32'd3);
    check("abort_a_done_at", 32'(done_at[0]), 32'd6);
    check("abort_b_dreq",    32'(c_dreq[1]),  32'd1);
    check("abort_b_done_at", 32'(done_at[1]), 32'd7);
`endif

    // Maximum length with repeated starts mid-burst
    clr_meas();
    pulse_start(16'hFFFF);
    step(100);
    pulse_start(16'd0);
    step(1000);
    pulse_start(16'd5);
    wait_idle(70000, "max_idle");
    step(2);
    check("max_a_dreq", 32'(c_dreq[0]), 32'd65535);
    check("max_b_dreq", 32'(c_dreq[1]), 32'd65535);
    check("max_a_err",  32'(c_err[0]),  32'd0);
    check("max_b_done", 32'(c_done[1]), 32'd1);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nand_phy_dqs_wr_seq.md
NAND_PHY_DQS_WR_SEQ -- requirements
Module: nand_phy_dqs_wr_seq

Interface
REQ-001 SHALL have parameter PRE_CYCLES, default 1: write-preamble length in clk0 cycles, legal 1..15.
REQ-002 SHALL have parameter PST_CYCLES, default 1: write-postamble length in clk0 cycles, legal 1..15.
REQ-003 SHALL have parameter LEN_W, default 16: width of the burst-length input.
REQ-004 clk0  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst0_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_start  input  1  one-cycle request to start a write burst.
REQ-007 wr_cycles  input  LEN_W  burst length in DQS toggle periods; sampled with wr_start.
REQ-008 busy  output  1  high from acceptance until return to IDLE.
REQ-009 done  output  1  one-cycle pulse when a burst finishes.
REQ-010 wr_err  output  1  one-cycle pulse when a request is rejected.
REQ-011 data_req  output  1  high in every cycle where DQ write data must be presented to the PHY.
REQ-012 dq_oe_n  output  1  DQ output enable, active-low.
REQ-013 dqs_oe_n  output  1  DQS output enable to the DQS IOB, active-low (1 = pad tristated).
REQ-014 dqs_rst_n  output  1  DQS toggle enable to the DQS IOB; 0 holds DQS low.

Function
REQ-015 SHALL implement the states IDLE, PRE, DATA and PST, with all outputs registered.
REQ-016 IDLE: dqs_oe_n=1, dq_oe_n=1, dqs_rst_n=0, data_req=0, busy=0.
REQ-017 In IDLE, wr_start=1 with wr_cycles!=0 SHALL latch wr_cycles and enter PRE on the same edge; outputs reflect PRE from the next cycle (1-cycle latency).
REQ-018 In IDLE, wr_start=1 with wr_cycles==0 SHALL stay in IDLE and pulse wr_err for 1 cycle on the next cycle.
REQ-019 PRE: dqs_oe_n=0, dqs_rst_n=0 (DQS driven low), dq_oe_n=1, busy=1; lasts exactly PRE_CYCLES cycles, then DATA.
REQ-020 DATA: dqs_oe_n=0, dqs_rst_n=1, dq_oe_n=0, data_req=1; lasts exactly the latched wr_cycles cycles, then PST.
REQ-021 PST: dqs_oe_n=0, dqs_rst_n=0, dq_oe_n=1, data_req=0; lasts exactly PST_CYCLES cycles, then IDLE.
REQ-022 done SHALL pulse 1 cycle, coincident with the first IDLE cycle after PST.
REQ-023 wr_start while busy=1 SHALL be ignored: no wr_err, no effect on the current burst.
REQ-024 A new wr_start in the same cycle done=1 SHALL be accepted; minimum gap between bursts is 1 IDLE cycle.
REQ-025 The down-counter SHALL be LEN_W bits wide; wr_cycles = 2^LEN_W-1 SHALL produce exactly that many DATA cycles with no wrap.

Reset
REQ-026 rst0_n=0 SHALL asynchronously force IDLE and IDLE output values, with done=0, wr_err=0 and the counter cleared, including mid-burst.
REQ-027 After rst0_n deasserts, the first wr_start SHALL be honoured no earlier than the first rising edge with rst0_n=1.

Configuration
REQ-028 With macro NAND_DQS_WR_ABORT_EN defined, the block SHALL add input wr_abort (1 bit). wr_abort=1 in PRE or DATA SHALL move the block to PST on the next edge. The full PST and the done pulse follow as normal. wr_abort is ignored in IDLE and PST.
REQ-029 Without NAND_DQS_WR_ABORT_EN, the port wr_abort and its logic SHALL be absent; bursts always run to completion.

Verification
REQ-030 PRE=1, PST=1, wr_start with wr_cycles=4 -> dqs_oe_n low 6 cycles; dqs_rst_n high 4 cycles; data_req high 4 cycles; done on cycle 7.
REQ-031 wr_start with wr_cycles=0 -> wr_err pulse 1 cycle; busy stays 0; dqs_oe_n stays 1.
REQ-032 PRE=3, PST=2, wr_cycles=1, second wr_start in the done cycle -> two back-to-back bursts each 3+1+2 cycles, separated by 1 IDLE cycle.
REQ-033 rst0_n pulled low during DATA cycle 2 of 8 -> outputs go to IDLE values without waiting for an edge; no done pulse.
REQ-034 NAND_DQS_WR_ABORT_EN defined, wr_cycles=10, wr_abort in DATA cycle 3 -> 3 data_req cycles, then PST_CYCLES of PST, then done.
REQ-035 wr_cycles=65535, wr_start repeated mid-burst -> exactly 65535 data_req cycles; repeated starts have no effect.
